// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants, frame field encodings and receiver state encoding.
package uart_pkg;
  localparam int OS_RATE_DEF = 16;
  localparam logic [1:0] PAR_EVEN = 2'b00;
  localparam logic [1:0] PAR_ODD = 2'b01;
  localparam logic [1:0] PAR_NONE = 2'b10;
  localparam logic [1:0] STOP_ONE = 2'b00;
  localparam logic [1:0] STOP_TWO = 2'b01;
  localparam int ST_IDLE = 0;
  localparam int ST_START = 1;
  localparam int ST_DATA = 2;
  localparam int ST_PARITY = 3;
  localparam int ST_STOP = 4;
  localparam int ST_WAIT = 5;
  typedef enum logic [5:0] {
    IDLE = 6'(1 << ST_IDLE),
    START = 6'(1 << ST_START),
    DATA = 6'(1 << ST_DATA),
    PARITY = 6'(1 << ST_PARITY),
    STOP = 6'(1 << ST_STOP),
    WAIT_IDLE = 6'(1 << ST_WAIT)
  } state_t;
endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchronizer for asynchronous inputs, reset to a chosen level.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) {q, m} <= {2{RST_VAL}};
    else {q, m} <= {m, d};
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampled UART receiver with mid-bit sampling, configurable frame format
// and parity/framing error reporting.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DLY = 1,
  parameter int DATA_WIDTH = 8,
  parameter int OS_RATE = OS_RATE_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [3:0]            data_bits,
  input  logic [1:0]            parity_mode,
  input  logic [1:0]            stop_bits,
  input  logic                  os_en_i,
  input  logic                  rx_i,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_vld_o,
  output logic                  parity_err_o,
  output logic                  frame_err_o,
  output logic                  rx_busy_o
);
  localparam int TW = $clog2(OS_RATE);
  localparam logic [TW-1:0] MID = TW'(OS_RATE / 2 - 1);
  localparam logic [TW-1:0] LAST = TW'(OS_RATE - 1);
  state_t state, state_nxt;
  logic rx_s, rx_prev, start, sample, last_bit, done, ferr_nxt;
  logic [TW-1:0] tick;
  logic [3:0] bit_cnt, nb, db_clamp;
  logic par_en, par_odd, two_stop, stop_cnt, perr, ferr;
  logic [DATA_WIDTH-1:0] shift;
  logic unused_dly;
  assign unused_dly = DLY != 0;
  uart_sync2 #(.RST_VAL(1'b1)) u_sync (.clk_i(clk_i), .rst_n_i(rst_n_i), .d(rx_i), .q(rx_s));
  assign start = rx_prev && !rx_s;
  assign sample = os_en_i && tick == MID;
  assign last_bit = bit_cnt == nb - 4'd1;
  assign ferr_nxt = ferr || !rx_s;
  assign rx_busy_o = state != IDLE;
  assign db_clamp = data_bits < 4'd5 ? 4'd5 : data_bits > 4'(DATA_WIDTH) ? 4'(DATA_WIDTH) : data_bits;
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    done = 1'b0;
    case (state)
      IDLE: state_nxt = start ? START : IDLE;
      START: if (sample) state_nxt = rx_s ? IDLE : DATA;
      DATA: if (sample && last_bit) state_nxt = par_en ? PARITY : STOP;
      PARITY: if (sample) state_nxt = STOP;
      STOP: if (sample && (!two_stop || stop_cnt)) begin
        done = 1'b1;
        state_nxt = ferr_nxt ? WAIT_IDLE : IDLE;
      end
      WAIT_IDLE: state_nxt = rx_s ? IDLE : WAIT_IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  // shift is cleared at start, so bits beyond the configured width stay zero
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      rx_prev <= 1'b1;
      tick <= '0;
      bit_cnt <= '0;
      nb <= '0;
      par_en <= 1'b0;
      par_odd <= 1'b0;
      two_stop <= 1'b0;
      stop_cnt <= 1'b0;
      perr <= 1'b0;
      ferr <= 1'b0;
      shift <= '0;
      rx_data_o <= '0;
      rx_vld_o <= 1'b0;
      parity_err_o <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      rx_prev <= rx_s;
      rx_vld_o <= done;
      if (state == IDLE && start) begin
        tick <= '0;
        bit_cnt <= '0;
        stop_cnt <= 1'b0;
        perr <= 1'b0;
        ferr <= 1'b0;
        shift <= '0;
        nb <= db_clamp;
        par_en <= parity_mode == PAR_EVEN || parity_mode == PAR_ODD;
        par_odd <= parity_mode == PAR_ODD;
        two_stop <= stop_bits == STOP_TWO;
      end else if (os_en_i) tick <= tick == LAST ? '0 : tick + TW'(1);
      if (sample && state == DATA) begin
        shift <= shift | (DATA_WIDTH'(rx_s) << bit_cnt);
        bit_cnt <= bit_cnt + 4'd1;
      end
      if (sample && state == PARITY) perr <= rx_s != (^shift ^ par_odd);
      if (sample && state == STOP) begin
        ferr <= ferr_nxt;
        stop_cnt <= 1'b1;
      end
      if (done) begin
        rx_data_o <= shift;
        parity_err_o <= perr;
        frame_err_o <= ferr_nxt;
      end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frame table plus hand sequences for glitch, break, reset and config latching.
module tb_uart_rx;
  logic clk = 1'b0, rst_n_i = 1'b0, os_en_i = 1'b0, rx_i = 1'b1;
  logic [3:0] data_bits = 4'd8;
  logic [1:0] parity_mode = 2'b10, stop_bits = 2'b00;
  logic [7:0] rx_data_o;
  logic rx_vld_o, parity_err_o, frame_err_o, rx_busy_o;
  int checks = 0, errors = 0, pulses = 0, os_div = 0;
  logic [7:0] cap_data = '0;
  logic cap_perr = 1'b0, cap_ferr = 1'b0;
  typedef struct {
    logic [3:0] db; logic [1:0] pm; logic [1:0] sb;
    int nb; bit par_on; bit pb; int ns; logic [1:0] sp; int gap;
    logic [7:0] d; logic [7:0] ed; bit ep; bit ef;
  } vec_t;
  vec_t v[10];
  uart_rx dut (
    .clk_i(clk), .rst_n_i(rst_n_i), .data_bits(data_bits), .parity_mode(parity_mode),
    .stop_bits(stop_bits), .os_en_i(os_en_i), .rx_i(rx_i), .rx_data_o(rx_data_o),
    .rx_vld_o(rx_vld_o), .parity_err_o(parity_err_o), .frame_err_o(frame_err_o),
    .rx_busy_o(rx_busy_o)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    os_div = (os_div + 1) % 4;
    os_en_i = os_div == 0;
  end
  always @(negedge clk)
    if (rx_vld_o) begin
      pulses++;
      cap_data = rx_data_o;
      cap_perr = parity_err_o;
      cap_ferr = frame_err_o;
    end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic bitp(input logic b);
    rx_i = b;
    repeat (64) @(negedge clk);
  endtask
  task automatic send(input logic [7:0] d, input int nb, input bit par_on, input bit pb,
                      input int ns, input logic [1:0] sp, input int gap);
    bitp(1'b0);
    for (int i = 0; i < nb; i++) bitp(d[i]);
    if (par_on) bitp(pb);
    for (int i = 0; i < ns; i++) bitp(sp[i]);
    for (int i = 0; i < gap; i++) bitp(1'b1);
  endtask
  task automatic chk_frame(input string tag, input int p0, input logic [7:0] ed,
                           input bit ep, input bit ef);
    chk({tag, " pulses"}, pulses - p0, 1);
    chk({tag, " data"}, cap_data, ed);
    chk({tag, " perr"}, cap_perr, ep);
    chk({tag, " ferr"}, cap_ferr, ef);
  endtask
  initial begin
    int p0;
    v[0] = '{4'd8, 2'b10, 2'b00, 8, 0, 0, 1, 2'b11, 1, 8'hA5, 8'hA5, 0, 0};
    v[1] = '{4'd8, 2'b00, 2'b00, 8, 1, 0, 1, 2'b11, 1, 8'h37, 8'h37, 1, 0};
    v[2] = '{4'd8, 2'b01, 2'b00, 8, 1, 0, 1, 2'b11, 1, 8'h37, 8'h37, 0, 0};
    v[3] = '{4'd7, 2'b10, 2'b01, 7, 0, 0, 2, 2'b11, 0, 8'hFF, 8'h7F, 0, 0};
    v[4] = '{4'd7, 2'b10, 2'b01, 7, 0, 0, 2, 2'b11, 1, 8'h80, 8'h00, 0, 0};
    v[5] = '{4'd3, 2'b11, 2'b10, 5, 0, 0, 1, 2'b11, 1, 8'hFF, 8'h1F, 0, 0};
    v[6] = '{4'd15, 2'b01, 2'b01, 8, 1, 1, 2, 2'b11, 1, 8'hC3, 8'hC3, 0, 0};
    v[7] = '{4'd6, 2'b00, 2'b00, 6, 1, 1, 1, 2'b11, 1, 8'h2A, 8'h2A, 0, 0};
    v[8] = '{4'd8, 2'b10, 2'b00, 8, 0, 0, 1, 2'b00, 1, 8'h5A, 8'h5A, 0, 1};
    v[9] = '{4'd7, 2'b10, 2'b01, 7, 0, 0, 2, 2'b01, 1, 8'h11, 8'h11, 0, 1};
    repeat (5) @(negedge clk);
    chk("rst data", rx_data_o, 0);
    chk("rst vld", rx_vld_o, 0);
    chk("rst perr", parity_err_o, 0);
    chk("rst ferr", frame_err_o, 0);
    chk("rst busy", rx_busy_o, 0);
    rst_n_i = 1'b1;
    repeat (64) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      data_bits = v[k].db;
      parity_mode = v[k].pm;
      stop_bits = v[k].sb;
      p0 = pulses;
      send(v[k].d, v[k].nb, v[k].par_on, v[k].pb, v[k].ns, v[k].sp, v[k].gap);
      chk_frame($sformatf("vec%0d", k), p0, v[k].ed, v[k].ep, v[k].ef);
      if (v[k].gap > 0) chk($sformatf("vec%0d busy", k), rx_busy_o, 0);
    end
    data_bits = 4'd8; parity_mode = 2'b10; stop_bits = 2'b00;
    p0 = pulses;
    fork
      send(8'hA5, 8, 0, 0, 1, 2'b11, 1);
      begin
        repeat (64 * 3) @(negedge clk);
        data_bits = 4'd5; parity_mode = 2'b00; stop_bits = 2'b01;
      end
    join
    chk_frame("cfglatch", p0, 8'hA5, 0, 0);
    data_bits = 4'd8; parity_mode = 2'b10; stop_bits = 2'b00;
    p0 = pulses;
    rx_i = 1'b0;
    repeat (8) @(negedge clk);
    chk("glitch busy", rx_busy_o, 1);
    repeat (8) @(negedge clk);
    rx_i = 1'b1;
    repeat (128) @(negedge clk);
    chk("glitch pulses", pulses - p0, 0);
    chk("glitch idle", rx_busy_o, 0);
    p0 = pulses;
    rx_i = 1'b0;
    repeat (30 * 64) @(negedge clk);
    chk_frame("break", p0, 8'h00, 0, 1);
    chk("break hold", rx_busy_o, 1);
    rx_i = 1'b1;
    repeat (64) @(negedge clk);
    chk("break release", rx_busy_o, 0);
    chk("break single", pulses - p0, 1);
    p0 = pulses;
    send(8'h55, 8, 0, 0, 1, 2'b11, 1);
    chk_frame("after break", p0, 8'h55, 0, 0);
    p0 = pulses;
    fork
      send(8'hC3, 8, 0, 0, 1, 2'b11, 1);
      begin
        repeat (64 * 4) @(negedge clk);
        rst_n_i = 1'b0;
        #2;
        chk("midrst data", rx_data_o, 0);
        chk("midrst vld", rx_vld_o, 0);
        chk("midrst perr", parity_err_o, 0);
        chk("midrst ferr", frame_err_o, 0);
        chk("midrst busy", rx_busy_o, 0);
      end
    join
    chk("midrst pulses", pulses - p0, 0);
    rst_n_i = 1'b1;
    repeat (64) @(negedge clk);
    p0 = pulses;
    send(8'h3C, 8, 0, 0, 1, 2'b11, 1);
    chk_frame("after rst", p0, 8'h3C, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receive stage, the far-end consumer of the serial line driven by the UART transmitter. It recovers frames from rx_i using a 16x oversampling tick from the shared baud generator and samples each bit at mid-bit. Frame format is runtime-configurable with the same data_bits / parity_mode / stop_bits fields as the transmitter. It delivers the parallel byte with a one-cycle valid pulse and error flags to the register/FIFO layer.

Parameters:
DLY, 1, simulation assignment delay on sequential outputs
DATA_WIDTH, 8, maximum data bits per frame and width of rx_data_o
OS_RATE, 16, oversample ticks per bit; mid-bit sample at tick OS_RATE/2-1

Ports:
clk_i  input  1  primary clock
rst_n_i  input  1  asynchronous active-low reset
data_bits  input  4  data bits per frame, 5..DATA_WIDTH
parity_mode  input  2  00 even, 01 odd, 10 none, 11 treated as none
stop_bits  input  2  00 one stop bit, 01 two stop bits, others one
os_en_i  input  1  one-cycle oversample tick, OS_RATE per bit period
rx_i  input  1  asynchronous serial line, idle high
rx_data_o  output  DATA_WIDTH  received data, LSB first on line, zero-extended
rx_vld_o  output  1  one-cycle pulse, frame complete
parity_err_o  output  1  parity mismatch for frame flagged by rx_vld_o
frame_err_o  output  1  stop bit sampled low for frame flagged by rx_vld_o
rx_busy_o  output  1  high whenever FSM not IDLE

Behaviour:
- Reset: rx_data_o=0, rx_vld_o=0, parity_err_o=0, frame_err_o=0, rx_busy_o=0. Synchronizer flops reset to 1. FSM resets to IDLE.
- Reset mid-frame aborts the frame. No rx_vld_o pulse is produced for it.
- rx_i passes through a 2-flop synchronizer. All logic uses the synchronized value rx_s.
- FSM uses one-hot states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- IDLE: a high-to-low transition of rx_s (previous 1, current 0) moves to START. Tick counter clears. data_bits, parity_mode and stop_bits are latched and held for the whole frame.
- Tick counter increments on os_en_i only. A bit sample occurs on the os_en_i where the counter equals the sample point. The counter then wraps to 0 at OS_RATE-1.
- START: at the mid-bit sample point (tick 7), rx_s=1 is a false start and returns to IDLE with no outputs. rx_s=0 moves to DATA with bit counter 0.
- DATA: each bit sample writes rx_s into shift[bit_cnt]. On the sample of bit data_bits-1, go to PARITY if parity is enabled, else go to STOP.
- PARITY: the sampled bit is compared against the XOR of the received data bits. Even mode expects XOR; odd mode expects ~XOR. A mismatch sets an internal perr flag.
- STOP: the first stop sample low sets an internal ferr flag. With two stop bits, a second sample is taken one bit period later, and a low there also sets ferr.
- Completion occurs on the last stop-bit sample. In the next cycle: rx_data_o = shift, with bits at index >= data_bits forced to 0. parity_err_o = perr and frame_err_o = ferr. rx_vld_o pulses for exactly one clk_i cycle.
- After completion, go to IDLE if no frame error, else go to WAIT_IDLE.
- WAIT_IDLE (break/line-low handling): remain until rx_s=1, then go to IDLE. No new start detection happens while in this state.
- rx_data_o and the error flags hold until the next completion. A frame with errors still produces rx_vld_o.
- Latency: rx_vld_o rises 1 clk after the os_en_i of the final stop-bit sample, i.e. mid-stop-bit, so back-to-back frames are accepted.
- data_bits below 5 is treated as 5. data_bits above DATA_WIDTH is treated as DATA_WIDTH.
- Config changes mid-frame are ignored because the fields are latched at start.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding localparams
  - parity mode constants PAR_EVEN/PAR_ODD/PAR_NONE
  - stop bit constants
  - OS_RATE default
- One sub-module, uart_sync2: 2-flop synchronizer with reset value parameter. It is reused by other async inputs.

Test Plan:
- 8N1, byte 0xA5, os_en_i every 4 clk -> one rx_vld_o pulse, rx_data_o=0xA5, both error flags 0, rx_busy_o low after.
- 8E1, byte 0x37 with wrong parity bit 0 (correct is 1) -> rx_data_o=0x37, parity_err_o=1, frame_err_o=0. Repeat with 8O1 and correct bit 0 -> parity_err_o=0.
- 7N2, byte 0x7F followed by 0x00 back-to-back with two stop bits -> two pulses, 0x7F then 0x00, upper bit forced 0.
- Glitch: rx_i low for 4 ticks then high -> no rx_vld_o, FSM back in IDLE, rx_busy_o 0.
- Line held low 30 bit periods (break) -> one pulse with rx_data_o=0x00 and frame_err_o=1. No further pulse until rx_i returns high and a new frame of 0x55 arrives, which gives rx_data_o=0x55 with no errors.
- Assert rst_n_i low during DATA of byte 0xC3 -> all outputs 0 immediately, no pulse. The next full frame 0x3C is received correctly.
